// File: rtl/cla_4_bits.sv
`default_nettype none
// ============================================================================
// Module   : cla_4_bits
// Purpose  : 4-bit carry-lookahead adder. {Cout,Sum} = A + B + Cin, with every
//            carry formed as a flat two-level sum-of-products (no ripple path).
//            Exports group propagate/generate so a second-level lookahead unit
//            can be cascaded, and a signed-overflow flag.
// Ports    : clk    in  1  clock (used only with CLA_OUT_REG_EN)
//            rst_n  in  1  synchronous active-low reset (CLA_OUT_REG_EN only)
//            A      in  4  operand A
//            B      in  4  operand B
//            Cin    in  1  carry in
//            Sum    out 4  (A + B + Cin) mod 16
//            Cout   out 1  carry out of bit 3
//            Pg     out 1  group propagate
//            Gg     out 1  group generate
//            Ovf    out 1  signed overflow (c4 ^ c3)
// Config   : CLA_OUT_REG_EN - when defined, all five outputs are registered
//            (one cycle latency, reset clears them). Undefined: combinational.
// Revision : 1.0 - initial release
// ============================================================================
module cla_4_bits (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout,
  output logic       Pg,
  output logic       Gg,
  output logic       Ovf
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [4:0] w_c;
  logic [3:0] w_sum;
  logic       w_pg;
  logic       w_gg;
  logic       w_ovf;

  // Per-bit propagate / generate terms
  generate
    for (genvar i = 0; i < 4; i++) begin : g_bit
      assign w_p[i] = A[i] ^ B[i];
      assign w_g[i] = A[i] & B[i];
    end
  endgenerate

  // Each carry is expanded directly in terms of p, g and Cin so that every
  // carry is two gate levels deep instead of depending on the previous one.
  assign w_c[0] = Cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & Cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & Cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & Cin);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & Cin);

  assign w_sum = w_p ^ w_c[3:0];

  // Group terms exclude Cin so an upper-level unit can form c4 = Gg | Pg&Cin
  assign w_pg  = &w_p;
  assign w_gg  = w_g[3]
               | (w_p[3] & w_g[2])
               | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

  // Carry into and out of the sign bit disagree exactly on signed overflow
  assign w_ovf = w_c[4] ^ w_c[3];

`ifdef CLA_OUT_REG_EN
  logic [3:0] r_sum;
  logic       r_cout;
  logic       r_pg;
  logic       r_gg;
  logic       r_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum  <= 4'd0;
      r_cout <= 1'b0;
      r_pg   <= 1'b0;
      r_gg   <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_c[4];
      r_pg   <= w_pg;
      r_gg   <= w_gg;
      r_ovf  <= w_ovf;
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign Pg   = r_pg;
  assign Gg   = r_gg;
  assign Ovf  = r_ovf;
`else
  // clk and rst_n exist only to keep the port list identical across builds
  logic w_unused_ctrl;
  assign w_unused_ctrl = clk ^ rst_n;

  assign Sum  = w_sum;
  assign Cout = w_c[4];
  assign Pg   = w_pg;
  assign Gg   = w_gg;
  assign Ovf  = w_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_4_bits.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_4_bits
// Purpose  : Self-checking bench for cla_4_bits. Results are compared against
//            an arithmetic reference computed from integer addition. Handles
//            both the combinational build and the CLA_OUT_REG_EN build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_4_bits;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic       Cin;
  logic [3:0] Sum;
  logic       Cout;
  logic       Pg;
  logic       Gg;
  logic       Ovf;

  int checks   = 0;
  int failures = 0;

  cla_4_bits dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Sum  (Sum),
    .Cout (Cout),
    .Pg   (Pg),
    .Gg   (Gg),
    .Ovf  (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {Cout, Sum[3:0], Pg, Gg, Ovf} from plain integer arithmetic
  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic cin);
    int         s;
    int         sa;
    logic [3:0] sm;
    logic       co, pg, gg, ov;
    s  = int'(a) + int'(b) + int'(cin);
    co = (s > 15);
    sm = s[3:0];
    pg = ((a ^ b) == 4'hF);          // every bit would pass an incoming carry
    gg = ((int'(a) + int'(b)) > 15); // carry out even with Cin = 0
    sa = int'($signed(a));
    sa = sa + int'($signed(b));
    sa = sa + int'(cin);
    ov = (sa > 7) || (sa < -8);
    return {co, sm, pg, gg, ov};
  endfunction

  function automatic logic [7:0] observed();
    return {Cout, Sum, Pg, Gg, Ovf};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed={Cout,Sum,Pg,Gg,Ovf}=%b required=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin);
    A   = a;
    B   = b;
    Cin = cin;
  endtask

`ifdef CLA_OUT_REG_EN
  // Apply on the falling edge, look at the result after the next rising edge
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic cin);
    @(negedge clk);
    drive(a, b, cin);
    @(posedge clk);
    #1;
  endtask
`else
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic cin);
    drive(a, b, cin);
    #5;
  endtask
`endif

  // Directed corner vectors: {A, B, Cin}
  logic [8:0] dir_vec [8] = '{
    {4'd0,  4'd0,  1'b0},
    {4'd15, 4'd1,  1'b0},
    {4'd7,  4'd1,  1'b0},
    {4'd5,  4'd10, 1'b1},
    {4'd5,  4'd10, 1'b0},
    {4'd15, 4'd15, 1'b1},
    {4'd8,  4'd8,  1'b0},
    {4'd8,  4'd15, 1'b1}
  };

  initial begin
    logic [3:0] ra, rb;
    logic       rc;
    int         sweep_bad;
    rst_n = 1'b1;
    drive(4'd0, 4'd0, 1'b0);

`ifdef CLA_OUT_REG_EN
    // Reset held for two edges while non-zero operands are presented
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'd15, 4'd15, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    check("reset_outputs_zero", observed(), 8'd0);

    // Release with A=3,B=4,Cin=1: result appears exactly one edge later
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd3, 4'd4, 1'b1);
    @(posedge clk); #1;
    check("first_after_reset_sum8", observed(), model(4'd3, 4'd4, 1'b1));

    // Reset mid-stream discards the operand presented in that cycle
    @(negedge clk);
    rst_n = 1'b0;
    drive(4'd7, 4'd1, 1'b0);
    @(posedge clk); #1;
    check("midstream_reset_zero", observed(), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
`else
    // Combinational build must not depend on clk or rst_n
    rst_n = 1'b0;
    step(4'd3, 4'd4, 1'b1);
    check("rst_n_ignored", observed(), model(4'd3, 4'd4, 1'b1));
    rst_n = 1'b1;
`endif

    // Hand-computed spot values for the documented corners
    step(4'd0, 4'd0, 1'b0);
    check("zero_plus_zero", observed(), {1'b0, 4'd0, 1'b0, 1'b0, 1'b0});
    step(4'd15, 4'd1, 1'b0);
    check("15_plus_1", observed(), {1'b1, 4'd0, 1'b0, 1'b1, 1'b0});
    step(4'd7, 4'd1, 1'b0);
    check("7_plus_1_ovf", observed(), {1'b0, 4'd8, 1'b0, 1'b0, 1'b1});
    step(4'd5, 4'd10, 1'b1);
    check("prop_chain_cin1", observed(), {1'b1, 4'd0, 1'b1, 1'b0, 1'b0});
    step(4'd5, 4'd10, 1'b0);
    check("prop_chain_cin0", observed(), {1'b0, 4'd15, 1'b1, 1'b0, 1'b0});
    step(4'd15, 4'd15, 1'b1);
    check("15_15_cin1", observed(), {1'b1, 4'd15, 1'b0, 1'b1, 1'b0});
    step(4'd8, 4'd8, 1'b0);
    check("8_plus_8_ovf", observed(), {1'b1, 4'd0, 1'b0, 1'b1, 1'b1});

    // Same corners against the reference model
    for (int i = 0; i < 8; i++) begin
      step(dir_vec[i][8:5], dir_vec[i][4:1], dir_vec[i][0]);
      check($sformatf("directed_%0d", i), observed(),
            model(dir_vec[i][8:5], dir_vec[i][4:1], dir_vec[i][0]));
    end

    // Exhaustive sweep of all 512 operand combinations
    sweep_bad = 0;
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = v[8:0];
      step(vv[8:5], vv[4:1], vv[0]);
      if (observed() !== model(vv[8:5], vv[4:1], vv[0])) begin
        if (sweep_bad < 4)
          check($sformatf("sweep_A%0d_B%0d_C%0d", vv[8:5], vv[4:1], vv[0]),
                observed(), model(vv[8:5], vv[4:1], vv[0]));
        sweep_bad++;
      end
    end
    checks++;
    assert (sweep_bad == 0)
    else begin
      failures++;
      $error("FAIL exhaustive_sweep observed_errors=%0d required_errors=0", sweep_bad);
    end

    // Randomised back-to-back operands
    for (int n = 0; n < 200; n++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      step(ra, rb, rc);
      check($sformatf("random_%0d", n), observed(), model(ra, rb, rc));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
